seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that computes `a + (b ^ {WIDTH{invert_b}}) + c_in` one CHUNK-bit slice per clock, with the chunk carry held in a register between cycles. It replaces wide ripple chains where the critical path must stay at one CHUNK-bit adder, and serves slow-path arithmetic such as wide address and counter updates. Operands enter through a valid/ready handshake; the result is held under output backpressure. It also reports signed overflow, which the fixed-width adders do not.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/chunk_adder.sv | 33 +++
 rtl/seq_chunk_adder.sv | 129 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_pkg
// Purpose : Shared types and sizing helpers for the sequential chunk adder.
//           state_t    - controller states (IDLE, BUSY, DONE)
//           n_chunks() - number of CHUNK-bit slices in a WIDTH-bit operand
//           idx_width()- bits needed for the chunk index (at least 1)
// Revision: 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        if (nchunk <= 1) begin
            return 1;
        end
        return $clog2(nchunk);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module  : chunk_adder
// Purpose : Purely combinational N-bit ripple-carry adder.
// Ports   : a, b  [N]  addends
//           c_in  [1]  carry into bit 0
//           sum   [N]  a + b + c_in (low N bits)
//           c_out [1]  carry out of bit N-1
// Revision: 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] w_carry;

    assign w_carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module  : seq_chunk_adder
// Purpose : Multi-cycle adder/subtractor computing
//           a + (b ^ {WIDTH{invert_b}}) + c_in one CHUNK-bit slice per clock,
//           with signed-overflow reporting.
// Ports   : clk, reset          clock, synchronous active-high reset
//           in_valid/in_ready   operand handshake (ready only in IDLE)
//           a, b, invert_b,c_in operands
//           out_valid/out_ready result handshake (valid only in DONE)
//           sum, c_out, overflow result, held stable while out_valid
// Revision: 1.0 - initial release
// ============================================================================
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int c_nchunk = n_chunks(WIDTH, CHUNK);
    localparam int c_idx_w  = idx_width(c_nchunk);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: CHUNK must divide WIDTH");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // B already conditionally inverted
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_overflow;

    int                 w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_chunk_sum;
    logic               w_chunk_carry;

    always_comb begin
        w_base    = int'(r_idx) * CHUNK;
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
    end

    chunk_adder #(
        .N (CHUNK)
    ) u_chunk_adder (
        .a     (w_a_chunk),
        .b     (w_b_chunk),
        .c_in  (r_carry),
        .sum   (w_chunk_sum),
        .c_out (w_chunk_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{invert_b}};
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_sum[w_base +: CHUNK] <= w_chunk_sum;
                    r_carry                <= w_chunk_carry;
                    if (r_idx == c_last_idx) begin
                        r_c_out <= w_chunk_carry;
                        // Same-sign operands producing an opposite-sign result.
                        r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                      (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_chunk_adder
// Purpose : Self-checking bench for seq_chunk_adder (32/8 and 16/16 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        invert_b = 1'b0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        c_out;
    logic        overflow;

    logic        iv16 = 1'b0;
    logic        ir16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        inv16 = 1'b0;
    logic        cin16 = 1'b0;
    logic        ov16;
    logic        or16 = 1'b0;
    logic [15:0] sum16;
    logic        co16;
    logic        ovf16;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [17:0] q16[$];

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .invert_b(invert_b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .invert_b(inv16), .c_in(cin16),
        .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .c_out(co16), .overflow(ovf16)
    );

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic minv, input logic mcin);
        exp_t        e;
        logic [31:0] be;
        logic [32:0] full;
        be    = minv ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, be} + {32'd0, mcin};
        e.sum = full[31:0];
        e.c   = full[32];
        e.ovf = (ma[31] == be[31]) && (full[31] != ma[31]);
        return e;
    endfunction

    // Present one operand set; returns #1 after the accepting edge.
    task automatic drive_op(input logic [31:0] va, input logic [31:0] vb,
                            input logic vinv, input logic vcin);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        end
        a = va; b = vb; invert_b = vinv; c_in = vcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic vinv, input logic vcin);
        q.push_back(model(va, vb, vinv, vcin));
        drive_op(va, vb, vinv, vcin);
    endtask

    // Wait for the result, compare latency and value, then complete the handshake.
    task automatic wait_result(input string name);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = q.pop_front();
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL %s_latency got=%0d required=4", name, lat);
        end
        total++;
        if ({sum, c_out, overflow} !== {e.sum, e.c, e.ovf}) begin
            bad++;
            $display("FAIL %s_result got sum=%h c=%b ovf=%b required sum=%h c=%b ovf=%b",
                     name, sum, c_out, overflow, e.sum, e.c, e.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL %s_return_idle got ready=%b valid=%b required ready=1 valid=0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, sum, c_out, overflow} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset32 got ready=%b valid=%b sum=%h c=%b ovf=%b required 1 0 0 0 0",
                     in_ready, out_valid, sum, c_out, overflow);
        end
        total++;
        if ({ir16, ov16, sum16, co16, ovf16} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset16 got ready=%b valid=%b sum=%h c=%b ovf=%b required 1 0 0 0 0",
                     ir16, ov16, sum16, co16, ovf16);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("add_wrap");
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);
        wait_result("add_cin");
    endtask

    task automatic test_subtract();
        send(32'd5, 32'd7, 1'b1, 1'b1);
        wait_result("sub_5_7");
        send(32'd7, 32'd5, 1'b1, 1'b1);
        wait_result("sub_7_5");
    endtask

    task automatic test_overflow();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("ovf_pos");
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_result("ovf_neg");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_result("random");
        end
    endtask

    task automatic test_backpressure();
        int   n;
        exp_t e;
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        e = q.pop_front();
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; invert_b = 1'($urandom_range(0, 1));
            c_in = 1'($urandom_range(0, 1));
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, sum, c_out, overflow} !== {1'b1, 1'b0, e.sum, e.c, e.ovf}) begin
                bad++;
                $display("FAIL bp_hold got valid=%b ready=%b sum=%h c=%b ovf=%b required 1 0 %h %b %b",
                         out_valid, in_ready, sum, c_out, overflow, e.sum, e.c, e.ovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release got ready=%b valid=%b required ready=1 valid=0",
                     in_ready, out_valid);
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_no_accept got ready=%b valid=%b required ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        // Carry propagates through every chunk, so the carry register is set when aborted.
        drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL abort_state got ready=%b valid=%b sum=%h required 1 0 00000000",
                     in_ready, out_valid, sum);
        end
        send(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        wait_result("after_abort");
    endtask

    task automatic test_wide16();
        int          lat;
        logic [16:0] full;
        logic [17:0] e;
        a16 = 16'h8000; b16 = 16'h8000; inv16 = 1'b0; cin16 = 1'b0;
        full = {1'b0, a16} + {1'b0, b16};
        q16.push_back({full[15:0], full[16],
                       (a16[15] == b16[15]) && (full[15] != a16[15])});
        iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = q16.pop_front();
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL w16_latency got=%0d required=1", lat);
        end
        total++;
        if ({sum16, co16, ovf16} !== e) begin
            bad++;
            $display("FAIL w16_result got sum=%h c=%b ovf=%b required sum=%h c=%b ovf=%b",
                     sum16, co16, ovf16, e[17:2], e[1], e[0]);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        total++;
        if ({ir16, ov16} !== 2'b10) begin
            bad++;
            $display("FAIL w16_return_idle got ready=%b valid=%b required ready=1 valid=0",
                     ir16, ov16);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_subtract();
        test_overflow();
        test_random();
        test_backpressure();
        test_reset_mid_busy();
        test_wide16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
